dccm_axi_reader: RTL

AXI4 read-initiator that fetches a contiguous block of 32-bit words from the DCCM's AXI slave port and streams them out on a valid/ready interface.
- Accepts one command (start address, word count) at a time.
- Splits the command into INCR bursts that respect MAX_BURST and 4 KB boundaries.
- Keeps one AR outstanding at a time.
- Sits between the core's DMA/prefetch logic and the DCCM AXI slave.

---
 rtl/dccm_axi_reader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/dccm_axi_reader.sv
// AXI4 INCR-burst read initiator: fetches a block of DCCM words and streams them out.
// Define DCCM_RD_TIMEOUT_EN to add the DATA-phase watchdog and the stray-beat sink.
module dccm_axi_reader #(
    parameter logic [3:0]  ID             = 4'h0,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        s_aclk,
    input  logic        s_aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic [31:0] m_axi_araddr,
    output logic [1:0]  m_axi_arburst,
    output logic [3:0]  m_axi_arid,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [3:0]  m_axi_rid,
    input  logic        m_axi_rlast,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic        dout_last,
    output logic        done,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StAddr, StData, StFin} state_e;

    localparam logic [16:0] MaxBurst = 17'(MAX_BURST);

    state_e      r_state, w_state_d;
    logic [31:0] r_addr;
    logic [15:0] r_rem;
    logic [8:0]  r_beats;
    logic [8:0]  r_cnt;
    logic        r_final;
    logic        r_err;
    logic        r_done;
    logic [31:0] r_sk_data [2];
    logic [1:0]  r_sk_last;
    logic [1:0]  r_sk_cnt;

    logic [1:0]  w_sk_cnt_d;
    logic [10:0] w_room;
    logic [16:0] w_lim;
    logic [8:0]  w_beats;
    logic [8:0]  w_beats_m1;
    logic        w_cmd_hs, w_ar_hs, w_r_hs, w_push, w_pop, w_push_last;
    logic        w_beat_err, w_timeout, w_sink, w_done_d;

    // Burst size: remaining words, capped by MAX_BURST and by the words left in this 4 KB page.
    always_comb begin
        w_room = 11'd1024 - {1'b0, r_addr[11:2]};
        w_lim  = {1'b0, r_rem};
        if (w_lim > MaxBurst) w_lim = MaxBurst;
        if (w_lim > {6'd0, w_room}) w_lim = {6'd0, w_room};
    end
    assign w_beats    = w_lim[8:0];
    assign w_beats_m1 = w_beats - 9'd1;

    assign w_cmd_hs    = cmd_valid && (r_state == StIdle);
    assign w_ar_hs     = m_axi_arready && (r_state == StAddr);
    assign w_r_hs      = m_axi_rvalid && (r_state == StData) && (r_sk_cnt != 2'd2);
    assign w_push      = w_r_hs;
    assign w_pop       = (r_sk_cnt != 2'd0) && dout_ready;
    assign w_push_last = r_final && (r_cnt == 9'd1);
    assign w_beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rid != ID)
                      || (m_axi_rlast != (r_cnt == 9'd1));

    assign cmd_ready     = (r_state == StIdle);
    assign busy          = (r_state != StIdle);
    assign m_axi_arvalid = (r_state == StAddr);
    assign m_axi_araddr  = m_axi_arvalid ? r_addr : 32'd0;
    assign m_axi_arlen   = m_axi_arvalid ? w_beats_m1[7:0] : 8'd0;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arid    = ID;
    assign m_axi_rready  = ((r_state == StData) && (r_sk_cnt != 2'd2)) || w_sink;
    assign dout_valid    = (r_sk_cnt != 2'd0);
    assign dout_data     = r_sk_data[0];
    assign dout_last     = r_sk_last[0];
    assign done          = r_done;
    assign err           = r_err;

`ifdef DCCM_RD_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] r_wd;
    logic           r_sink;

    assign w_timeout = (r_state == StData) && !w_r_hs && (r_wd == WdW'(TIMEOUT_CYCLES - 1));
    // After a timeout, swallow the abandoned burst so it cannot leak into the next command.
    assign w_sink    = (r_state == StIdle) && r_sink && (m_axi_rid == ID);

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_wd   <= '0;
            r_sink <= 1'b0;
        end else begin
            r_wd <= ((r_state != StData) || w_r_hs || w_timeout) ? '0 : r_wd + 1'b1;
            if (w_timeout) begin
                r_sink <= 1'b1;
            end else if (w_cmd_hs || (w_sink && m_axi_rvalid && m_axi_rlast)) begin
                r_sink <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_sink    = 1'b0;
`endif

    assign w_sk_cnt_d = w_timeout ? 2'd0
                                  : r_sk_cnt + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) w_state_d = (cmd_len == 16'd0) ? StFin : StAddr;
            end
            StAddr: begin
                if (m_axi_arready) w_state_d = StData;
            end
            StData: begin
                if (w_timeout) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end else if (w_r_hs && (r_cnt == 9'd1)) begin
                    w_state_d = r_final ? StFin : StAddr;
                end
            end
            StFin: begin
                if (w_sk_cnt_d == 2'd0) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_addr  <= 32'd0;
            r_rem   <= 16'd0;
            r_beats <= 9'd0;
            r_cnt   <= 9'd0;
            r_final <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done_d;
            if (w_cmd_hs) begin
                r_addr <= {cmd_addr[31:2], 2'b00};
                r_rem  <= cmd_len;
            end else if (w_ar_hs) begin
                r_beats <= w_beats;
                r_cnt   <= w_beats;
                r_final <= ({7'd0, w_beats} == r_rem);
            end else if (w_r_hs) begin
                r_cnt <= r_cnt - 9'd1;
                if (r_cnt == 9'd1) begin
                    r_addr <= r_addr + {21'd0, r_beats, 2'b00};
                    r_rem  <= r_rem - {7'd0, r_beats};
                end
            end
            if (w_cmd_hs) begin
                r_err <= 1'b0;
            end else if ((w_r_hs && w_beat_err) || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Two-entry skid FIFO, head always in slot 0 so dout_* come straight from flops.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_sk_cnt     <= 2'd0;
            r_sk_data[0] <= 32'd0;
            r_sk_data[1] <= 32'd0;
            r_sk_last    <= 2'b00;
        end else begin
            r_sk_cnt <= w_sk_cnt_d;
            if (!w_timeout) begin
                if (w_pop) begin
                    r_sk_data[0] <= r_sk_data[1];
                    r_sk_last[0] <= r_sk_last[1];
                end
                if (w_push) begin
                    if ((r_sk_cnt == 2'd0) || ((r_sk_cnt == 2'd1) && w_pop)) begin
                        r_sk_data[0] <= m_axi_rdata;
                        r_sk_last[0] <= w_push_last;
                    end else begin
                        r_sk_data[1] <= m_axi_rdata;
                        r_sk_last[1] <= w_push_last;
                    end
                end
            end
        end
    end
endmodule
